spi_xfer_scheduler: RTL

- Sits between the two SPI requesters and the frame configuration decoder / serial shifter pair.
- Requester 0 is the host CSR command path and supplies a full frame descriptor.
- Requester 1 is the XIP fetch path and supplies only a flash address; the frame uses commandtype 3'b110 and fixed XIP parameters.
- The block arbitrates round-robin between the two, latches the winning descriptor, pulses setup_start to the decoder, waits for both decoder done flags, launches the shifter, and returns the received word with a per-requester ack. A watchdog aborts hung transfers.

---
 rtl/spi_xfer_scheduler.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_scheduler
// Brief    : Round-robin scheduler between the host CSR command path and the
//            XIP fetch path. Latches the winning frame descriptor, launches the
//            frame decoder and then the serial shifter, and returns the
//            received word with a per-requester ack. A watchdog aborts hung
//            transfers.
// Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_scheduler #(
    parameter int TO_W      = 10,
    parameter int XIP_NMISO = 32,
    parameter int XIP_DUMMY = 8
) (
    input  logic        clk,
    input  logic        rst,
    // host request
    input  logic        h_valid,
    output logic        h_ready,
    input  logic [7:0]  h_command,
    input  logic [2:0]  h_commandtype,
    input  logic [31:0] h_address,
    input  logic [31:0] h_datain,
    input  logic [6:0]  h_nmisobits,
    input  logic [6:0]  h_ndatatxbits,
    input  logic [3:0]  h_dummy,
    // XIP request
    input  logic        x_valid,
    output logic        x_ready,
    input  logic [31:0] x_address,
    // shared configuration
    input  logic [1:0]  cfg_spimode,
    input  logic [9:0]  cfg_frame_struct,
    input  logic        cfg_dtr_en,
    input  logic        cfg_4byte,
    // latched descriptor to decoder
    output logic [7:0]  command,
    output logic [2:0]  commandtype,
    output logic [31:0] address,
    output logic [31:0] datain,
    output logic [6:0]  nmisobits,
    output logic [6:0]  ndatatxbits,
    output logic [3:0]  dummy_cycles,
    output logic [1:0]  spimode,
    output logic [9:0]  frame_struct,
    output logic        dtr_en,
    output logic        fourbyteaddr_on,
    // decoder handshake
    output logic        setup_start,
    input  logic        build_done,
    input  logic        counters_done,
    // shifter handshake
    output logic        xfer_start,
    output logic        xfer_abort,
    input  logic        xfer_done,
    input  logic [31:0] rx_data,
    // response
    output logic        h_ack,
    output logic        x_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam logic [6:0] c_XIP_NMISO = 7'(XIP_NMISO);
    localparam logic [3:0] c_XIP_DUMMY = 4'(XIP_DUMMY);
    localparam logic [2:0] c_XIP_CTYPE = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WAIT_CFG = 3'd2,
        ST_LAUNCH   = 3'd3,
        ST_BUSY     = 3'd4,
        ST_RESP     = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_last_xip;     // last grant; also selects the ack
    logic              r_bd_seen;
    logic              r_cd_seen;
    logic [TO_W-1:0]   r_wd;
    logic              r_err;
    logic [31:0]       r_rdata;

    logic [7:0]        r_command;
    logic [2:0]        r_commandtype;
    logic [31:0]       r_address;
    logic [31:0]       r_datain;
    logic [6:0]        r_nmisobits;
    logic [6:0]        r_ndatatxbits;
    logic [3:0]        r_dummy;
    logic [1:0]        r_spimode;
    logic [9:0]        r_frame_struct;
    logic              r_dtr_en;
    logic              r_4byte;

    logic              w_h_win;
    logic              w_x_win;
    logic              w_timeout;
    logic              w_abort;
    logic              w_cap_rx;
    logic              w_wd_max;

    assign w_wd_max = &r_wd;

    // Next-state logic, arbitration and timeout decisions
    always_comb begin
        w_next    = r_state;
        w_h_win   = 1'b0;
        w_x_win   = 1'b0;
        w_timeout = 1'b0;
        w_abort   = 1'b0;
        w_cap_rx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie the requester that did not win last time goes first
                w_h_win = h_valid && (!x_valid || r_last_xip);
                w_x_win = x_valid && !w_h_win;
                if (w_h_win || w_x_win) begin
                    w_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_next = ST_WAIT_CFG;
            end
            ST_WAIT_CFG: begin
                // A flag arriving this cycle counts as captured already
                if ((r_bd_seen || build_done) && (r_cd_seen || counters_done)) begin
                    w_next = ST_LAUNCH;
                end else if (w_wd_max) begin
                    w_timeout = 1'b1;
                    w_next    = ST_RESP;
                end
            end
            ST_LAUNCH: begin
                w_next = ST_BUSY;
            end
            ST_BUSY: begin
                // A completion in the last watchdog cycle still wins
                if (xfer_done) begin
                    w_cap_rx = 1'b1;
                    w_next   = ST_RESP;
                end else if (w_wd_max) begin
                    w_timeout = 1'b1;
                    w_abort   = 1'b1;
                    w_next    = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant pointer and descriptor capture on the accepting handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_xip     <= 1'b1;
            r_command      <= '0;
            r_commandtype  <= '0;
            r_address      <= '0;
            r_datain       <= '0;
            r_nmisobits    <= '0;
            r_ndatatxbits  <= '0;
            r_dummy        <= '0;
            r_spimode      <= '0;
            r_frame_struct <= '0;
            r_dtr_en       <= 1'b0;
            r_4byte        <= 1'b0;
        end else if (w_h_win || w_x_win) begin
            r_last_xip     <= w_x_win;
            r_spimode      <= cfg_spimode;
            r_frame_struct <= cfg_frame_struct;
            r_dtr_en       <= cfg_dtr_en;
            r_4byte        <= cfg_4byte;
            if (w_h_win) begin
                r_command     <= h_command;
                r_commandtype <= h_commandtype;
                r_address     <= h_address;
                r_datain      <= h_datain;
                r_nmisobits   <= h_nmisobits;
                r_ndatatxbits <= h_ndatatxbits;
                r_dummy       <= h_dummy;
            end else begin
                r_command     <= '0;
                r_commandtype <= c_XIP_CTYPE;
                r_address     <= x_address;
                r_datain      <= '0;
                r_nmisobits   <= c_XIP_NMISO;
                r_ndatatxbits <= '0;
                r_dummy       <= c_XIP_DUMMY;
            end
        end
    end

    // Sticky decoder-done flags and the saturating watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bd_seen <= 1'b0;
            r_cd_seen <= 1'b0;
            r_wd      <= '0;
        end else begin
            case (r_state)
                ST_SETUP: begin
                    r_bd_seen <= 1'b0;
                    r_cd_seen <= 1'b0;
                    r_wd      <= '0;
                end
                ST_WAIT_CFG: begin
                    if (build_done) begin
                        r_bd_seen <= 1'b1;
                    end
                    if (counters_done) begin
                        r_cd_seen <= 1'b1;
                    end
                    if (!w_wd_max) begin
                        r_wd <= r_wd + TO_W'(1);
                    end
                end
                ST_LAUNCH: begin
                    r_wd <= '0;
                end
                ST_BUSY: begin
                    if (!w_wd_max) begin
                        r_wd <= r_wd + TO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Response word and error flag; err lives only through the ack cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_cap_rx) begin
                r_rdata <= rx_data;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
            if (r_state == ST_RESP) begin
                r_err <= 1'b0;
            end
        end
    end

    assign h_ready         = w_h_win;
    assign x_ready         = w_x_win;
    assign setup_start     = (r_state == ST_SETUP);
    assign xfer_start      = (r_state == ST_LAUNCH);
    assign xfer_abort      = w_abort;
    assign h_ack           = (r_state == ST_RESP) && !r_last_xip;
    assign x_ack           = (r_state == ST_RESP) && r_last_xip;
    assign busy            = (r_state != ST_IDLE);
    assign rdata           = r_rdata;
    assign err             = r_err;

    assign command         = r_command;
    assign commandtype     = r_commandtype;
    assign address         = r_address;
    assign datain          = r_datain;
    assign nmisobits       = r_nmisobits;
    assign ndatatxbits     = r_ndatatxbits;
    assign dummy_cycles    = r_dummy;
    assign spimode         = r_spimode;
    assign frame_struct    = r_frame_struct;
    assign dtr_en          = r_dtr_en;
    assign fourbyteaddr_on = r_4byte;

endmodule
`default_nettype wire
